// File: rtl/pixel_writer.sv
// pixel_writer: queues plotted pixels and applies each one to a 1 bpp
// 640x480 framebuffer (16 pixels per word) by read-modify-write.
//
// Handshake: a pixel is taken on a rising edge where plot=1 and ready=1.
// ready is the registered "queue not full" flag, so a plot seen while
// ready=0 is discarded and sets the sticky overflow flag, even if the RMW
// engine pops an entry in that same cycle.
//
// Optional feature: define PIXEL_CLIP_COUNT_EN to add the clip_count output,
// a saturating count of pixels dropped for being off-screen.
//
// fsm_state mirrors the RMW state register (0=IDLE 1=READ 2=WAIT 3=WRITE)
// so checkers can follow the engine.
module pixel_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        plot,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        ink,
  output logic        ready,
  output logic        busy,
  output logic        overflow,
  output logic [14:0] ram_addr,
  output logic        ram_re,
  input  logic [15:0] ram_rdata,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
`ifdef PIXEL_CLIP_COUNT_EN
  output logic [15:0] clip_count,
`endif
  output logic [1:0]  fsm_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state, state_next;

  // Queue entry: {word[14:0], bit[3:0], ink}
  logic [19:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic [18:0] idx;
  logic        on_screen;
  logic        push;
  logic        pop;
  logic [19:0] head;

  // Latched pixel for the RMW in flight
  logic [14:0] cur_word;
  logic [3:0]  cur_bit;
  logic        cur_ink;

  // Next values of the registered RAM-side outputs
  logic        re_next;
  logic        we_next;
  logic [14:0] addr_next;
  logic [15:0] wdata_next;

  // y*640 as (y<<9)+(y<<7), all in 19-bit unsigned arithmetic
  assign idx       = {y, 9'b0} + {2'b0, y, 7'b0} + {9'b0, x};
  assign on_screen = (x < 10'd640) && (y < 10'd480);
  assign ready     = (count < DEPTH_C);
  assign push      = plot && ready && on_screen && !reset;
  assign head      = mem[rd_ptr];
  assign busy      = (count != '0) || (state != IDLE);
  assign fsm_state = state;

  // Queue storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {idx[18:4], idx[3:0], ink};
    end
  end

  // Next-state and next-output logic of the RMW engine
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    re_next    = 1'b0;
    we_next    = 1'b0;
    addr_next  = ram_addr;
    wdata_next = ram_wdata;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          re_next    = 1'b1;
          addr_next  = head[19:5];
          state_next = READ;
        end
      end
      READ: begin
        state_next = WAIT;
      end
      WAIT: begin
        // ram_rdata is valid now; merge the pixel straight into wdata
        wdata_next          = ram_rdata;
        wdata_next[cur_bit] = cur_ink;
        we_next             = 1'b1;
        addr_next           = cur_word;
        state_next          = WRITE;
      end
      WRITE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, queue pointers, flags and registered RAM outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cur_word  <= '0;
      cur_bit   <= '0;
      cur_ink   <= 1'b0;
    end else begin
      state     <= state_next;
      ram_re    <= re_next;
      ram_we    <= we_next;
      ram_addr  <= addr_next;
      ram_wdata <= wdata_next;
      if (plot && !ready) begin
        overflow <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cur_word <= head[19:5];
        cur_bit  <= head[4:1];
        cur_ink  <= head[0];
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef PIXEL_CLIP_COUNT_EN
  // Saturating count of accepted-but-off-screen pixels
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_count <= '0;
    end else if (plot && ready && !on_screen && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed test of pixel_writer against a framebuffer RAM
// model with one-cycle read latency. Define PIXEL_CLIP_COUNT_EN to also
// check clip_count.
module tb_pixel_writer;

  logic        clk;
  logic        reset;
  logic        plot;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        ink;
  logic        ready;
  logic        busy;
  logic        overflow;
  logic [14:0] ram_addr;
  logic        ram_re;
  logic [15:0] ram_rdata;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [1:0]  fsm_state;
`ifdef PIXEL_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif

  pixel_writer #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .plot      (plot),
    .x         (x),
    .y         (y),
    .ink       (ink),
    .ready     (ready),
    .busy      (busy),
    .overflow  (overflow),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
`ifdef PIXEL_CLIP_COUNT_EN
    .clip_count(clip_count),
`endif
    .fsm_state (fsm_state)
  );

  // ---------------- clock and reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- framebuffer RAM model ----------------
  logic [15:0] mem [0:19199];
  logic        poke_en;
  logic [14:0] poke_addr;
  logic [15:0] poke_data;

  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_addr];
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // ---------------- bus monitor ----------------
  int          cyc;
  int          busy_cycles;
  int          both_hi;
  int          re_cyc;
  int          we_cyc;
  logic [14:0] re_log[$];
  logic [30:0] we_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_re) begin
      re_log.push_back(ram_addr);
      re_cyc = cyc;
    end
    if (ram_we) begin
      we_log.push_back({ram_addr, ram_wdata});
      we_cyc = cyc;
    end
    if (ram_re && ram_we) both_hi = both_hi + 1;
    if (busy) busy_cycles = busy_cycles + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_fail;
  logic [30:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare logged writes against the expected queue, in order
  task automatic check_writes(input string tag);
    check({tag, "_we_count"}, 32'(we_log.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && we_log.size() > 0) begin
      check({tag, "_write"}, 32'(we_log.pop_front()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // All drivers start and end #1 after a rising edge.
  task automatic plot_px(input logic [9:0] px, input logic [9:0] py, input logic pink);
    plot = 1'b1;
    x    = px;
    y    = py;
    ink  = pink;
    @(posedge clk);
    #1;
    plot = 1'b0;
  endtask

  task automatic poke(input logic [14:0] a, input logic [15:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    if (busy) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    re_log.delete();
    we_log.delete();
    busy_cycles = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    busy_cycles = 0;
    both_hi     = 0;
    re_cyc      = 0;
    we_cyc      = 0;
    reset       = 1'b1;
    plot        = 1'b0;
    x           = '0;
    y           = '0;
    ink         = 1'b0;
    poke_en     = 1'b0;
    poke_addr   = '0;
    poke_data   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_ram_re", 32'(ram_re), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
`ifdef PIXEL_CLIP_COUNT_EN
    check("rst_clip_count", 32'(clip_count), 32'd0);
`endif

    // (3,0) ink=1 on an empty word: read addr 0, write 0x0008, 4 busy cycles
    poke(15'd0, 16'h0000);
    clear_logs();
    exp_q.push_back({15'd0, 16'h0008});
    plot_px(10'd3, 10'd0, 1'b1);
    wait_idle("p3_0");
    check("p3_0_re_count", 32'(re_log.size()), 32'd1);
    if (re_log.size() > 0) check("p3_0_re_addr", 32'(re_log[0]), 32'd0);
    check("p3_0_re_to_we", 32'(we_cyc - re_cyc), 32'd2);
    check("p3_0_busy_cycles", 32'(busy_cycles), 32'd4);
    check_writes("p3_0");
    check("p3_0_mem0", 32'(mem[0]), 32'h0008);

    // (639,479) ink=0 on a full word: addr 19199, wdata 0x7FFF
    poke(15'd19199, 16'hFFFF);
    clear_logs();
    exp_q.push_back({15'd19199, 16'h7FFF});
    plot_px(10'd639, 10'd479, 1'b0);
    wait_idle("p639_479");
    check("p639_479_re_count", 32'(re_log.size()), 32'd1);
    if (re_log.size() > 0) check("p639_479_re_addr", 32'(re_log[0]), 32'd19199);
    check_writes("p639_479");
    check("p639_479_mem", 32'(mem[19199]), 32'h7FFF);

    // Off-screen pixels are accepted but cause no RAM traffic
    clear_logs();
    plot_px(10'd640, 10'd5, 1'b1);
    plot_px(10'd0, 10'd480, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("clip_re_count", 32'(re_log.size()), 32'd0);
    check("clip_we_count", 32'(we_log.size()), 32'd0);
    check("clip_busy_cycles", 32'(busy_cycles), 32'd0);
    check("clip_overflow", 32'(overflow), 32'd0);
`ifdef PIXEL_CLIP_COUNT_EN
    check("clip_count", 32'(clip_count), 32'd2);
`endif

    // Back-to-back pixels in one word both land: 0x0003
    poke(15'd0, 16'h0000);
    clear_logs();
    exp_q.push_back({15'd0, 16'h0001});
    exp_q.push_back({15'd0, 16'h0003});
    plot_px(10'd0, 10'd0, 1'b1);
    plot_px(10'd1, 10'd0, 1'b1);
    wait_idle("same_word");
    check_writes("same_word");
    check("same_word_mem0", 32'(mem[0]), 32'h0003);
    check("same_word_overflow", 32'(overflow), 32'd0);

    // plot held 8 cycles at (16i+2, 2): word 80+i, bit 2.
    // Accepted i=0,1,2,3,4,6; i=5 and i=7 meet ready=0 and are dropped.
    for (int i = 0; i < 8; i++) poke(15'(80 + i), 16'h0000);
    clear_logs();
    exp_q.push_back({15'd80, 16'h0004});
    exp_q.push_back({15'd81, 16'h0004});
    exp_q.push_back({15'd82, 16'h0004});
    exp_q.push_back({15'd83, 16'h0004});
    exp_q.push_back({15'd84, 16'h0004});
    exp_q.push_back({15'd86, 16'h0004});
    plot = 1'b1;
    ink  = 1'b1;
    y    = 10'd2;
    for (int i = 0; i < 8; i++) begin
      x = 10'(i * 16 + 2);
      @(posedge clk);
      #1;
    end
    plot = 1'b0;
    check("burst_ready_low", 32'(ready), 32'd0);
    check("burst_overflow", 32'(overflow), 32'd1);
    wait_idle("burst");
    check("burst_re_count", 32'(re_log.size()), 32'd6);
    check_writes("burst");
    check("burst_mem85", 32'(mem[85]), 32'h0000);
    check("burst_mem87", 32'(mem[87]), 32'h0000);
    check("burst_overflow_sticky", 32'(overflow), 32'd1);
    check("burst_ready_after", 32'(ready), 32'd1);

    // Reset in WAIT abandons the RMW; a plot alongside reset is ignored
    poke(15'd120, 16'h0000);
    clear_logs();
    plot_px(10'd5, 10'd3, 1'b1);
    n = 0;
    while (fsm_state != 2'd2 && n < 20) begin
      @(posedge clk);
      #1;
      n = n + 1;
    end
    check("rst_wait_reached", 32'(fsm_state), 32'd2);
    clear_logs();
    reset = 1'b1;
    plot  = 1'b1;
    x     = 10'd7;
    y     = 10'd3;
    ink   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    plot  = 1'b0;
    check("rst_wait_we", 32'(ram_we), 32'd0);
    check("rst_wait_ready", 32'(ready), 32'd1);
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_overflow", 32'(overflow), 32'd0);
    check("rst_wait_state", 32'(fsm_state), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("rst_wait_we_count", 32'(we_log.size()), 32'd0);
    check("rst_wait_re_count", 32'(re_log.size()), 32'd0);
    check("rst_wait_mem120", 32'(mem[120]), 32'h0000);

    check("re_we_overlap", 32'(both_hi), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
